// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse symbol player:
//   - state_e   : player FSM encoding (IDLE, TONE, GAP)
//   - DOT/DASH  : element type values as stored in sym_bits
//   - DUR_W     : width of millisecond durations
//   - LEN_W     : width of the element count / element index
//   - UNIT_W    : width of the run-time unit time in ms
//   - scale_ms(): unit time multiplied by a unit count, in DUR_W bits
// -----------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // The longest duration is DASH_UNITS * 1023 ms; with DASH_UNITS <= 4 that
  // still fits in 12 bits (3 * 1023 = 3069 for the default dash).
  localparam int DUR_W  = 12;
  localparam int LEN_W  = 4;
  localparam int UNIT_W = 10;

  function automatic logic [DUR_W-1:0] scale_ms(input logic [UNIT_W-1:0] unit,
                                                input int                units);
    return DUR_W'(unit) * DUR_W'(units);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
// Millisecond prescaler. Counts enabled clock cycles and raises tick_o for one
// cycle on every CLK_PER_MS-th enabled cycle. clear_i restarts the count at 0
// on the next edge, so a new count period begins with no phase carried over.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   restart the prescaler (takes priority over en_i)
//   en_i     in   count enable
//   tick_o   out  one-cycle tick at the last cycle of each ms period
// -----------------------------------------------------------------------------
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int                CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The tick is not gated by clear_i: the owner derives its clear from this
  // tick, so gating here would close a combinational loop.
  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first, so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_sym_player.sv
// -----------------------------------------------------------------------------
// morse_sym_player
// Plays one Morse symbol of up to MAX_LEN elements on a buzzer pin. Each
// element is a dot (1 unit) or a dash (DASH_UNITS units); consecutive elements
// are separated by a silent gap of GAP_UNITS units. There is no trailing gap:
// spacing between symbols belongs to the sequencer above this block.
// Every state lasts exactly dur_ms * CLK_PER_MS clock periods.
//
// Parameters:
//   CLK_PER_MS  clock cycles per millisecond
//   MAX_LEN     maximum elements per symbol (<= 15)
//   DASH_UNITS  dash length in units (1..4)
//   GAP_UNITS   inter-element gap in units (1..4)
//   ACTIVE_LOW  1: pin_out=0 sounds the buzzer, 0: pin_out=1 sounds it
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request, sampled only in IDLE
//   abort     in   synchronous cancel, wins over start and expiry
//   sym_len   in   element count, clamped to MAX_LEN
//   sym_bits  in   element types, bit0 first, 1=dash 0=dot
//   unit_ms   in   unit time in ms, 0 treated as 1
//   busy      out  high while a symbol is playing
//   done      out  one-cycle completion pulse
//   pin_out   out  buzzer drive
// -----------------------------------------------------------------------------
module morse_sym_player
  import morse_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int MAX_LEN    = 8,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   sym_len,
  input  logic [MAX_LEN-1:0] sym_bits,
  input  logic [UNIT_W-1:0]  unit_ms,
  output logic               busy,
  output logic               done,
  output logic               pin_out
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic             PIN_ON    = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic             PIN_OFF   = ~PIN_ON;

  // Registered state
  state_e             state_q;
  logic [MAX_LEN-1:0] bits_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [DUR_W-1:0]   dot_q;
  logic [DUR_W-1:0]   dash_q;
  logic [DUR_W-1:0]   gap_q;
  logic [DUR_W-1:0]   ms_q;      // ms remaining in the current state
  logic               busy_q;
  logic               done_q;
  logic               pin_q;

  // Values derived from the inputs at accept time
  logic [LEN_W-1:0]   len_d;
  logic [UNIT_W-1:0]  unit_d;
  logic [DUR_W-1:0]   dot_d;
  logic [DUR_W-1:0]   dash_d;
  logic [DUR_W-1:0]   gap_d;
  logic [DUR_W-1:0]   first_ms_d;

  // Values derived from the latched symbol
  logic [LEN_W-1:0]   idx_d;
  logic [MAX_LEN-1:0] next_bits;
  logic [DUR_W-1:0]   next_tone_ms;

  logic tick;
  logic accept;
  logic expire;
  logic last_elem;
  logic tick_clear;

  always_comb begin
    len_d      = (sym_len > MAX_LEN_W) ? MAX_LEN_W : sym_len;
    unit_d     = (unit_ms == '0) ? UNIT_W'(1) : unit_ms;
    dot_d      = scale_ms(unit_d, 1);
    dash_d     = scale_ms(unit_d, DASH_UNITS);
    gap_d      = scale_ms(unit_d, GAP_UNITS);
    first_ms_d = (sym_bits[0] == DASH) ? dash_d : dot_d;

    // Shifting rather than indexing keeps the select width-clean for any
    // MAX_LEN; bit 0 of the shifted vector is the element to play next.
    idx_d        = idx_q + LEN_W'(1);
    next_bits    = bits_q >> idx_d;
    next_tone_ms = (next_bits[0] == DASH) ? dash_q : dot_q;
  end

  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign expire    = tick && (ms_q == DUR_W'(1));
  assign last_elem = (idx_q == (len_q - LEN_W'(1)));

  // Every state entry (accept, expiry, abort) restarts the ms prescaler.
  assign tick_clear = accept || expire || abort;

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tick_clear),
    .en_i    (state_q != ST_IDLE),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched symbol registers are reset along with the control
      // state; they are few, and this keeps every output X-free after reset.
      state_q <= ST_IDLE;
      bits_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      dot_q   <= '0;
      dash_q  <= '0;
      gap_q   <= '0;
      ms_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pin_q   <= PIN_OFF;
    end else begin
      done_q <= 1'b0;

      // Count down one ms per tick; reloads below override this on expiry.
      if (tick) begin
        ms_q <= ms_q - DUR_W'(1);
      end

      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        pin_q   <= PIN_OFF;
        idx_q   <= '0;
        ms_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              bits_q <= sym_bits;
              len_q  <= len_d;
              dot_q  <= dot_d;
              dash_q <= dash_d;
              gap_q  <= gap_d;
              idx_q  <= '0;
              if (len_d == '0) begin
                // Empty symbol: complete immediately without playing.
                done_q <= 1'b1;
              end else begin
                state_q <= ST_TONE;
                busy_q  <= 1'b1;
                pin_q   <= PIN_ON;
                ms_q    <= first_ms_d;
              end
            end
          end

          ST_TONE: begin
            if (expire) begin
              pin_q <= PIN_OFF;
              if (last_elem) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                idx_q   <= '0;
                ms_q    <= '0;
              end else begin
                state_q <= ST_GAP;
                ms_q    <= gap_q;
              end
            end
          end

          ST_GAP: begin
            if (expire) begin
              state_q <= ST_TONE;
              pin_q   <= PIN_ON;
              idx_q   <= idx_d;
              ms_q    <= next_tone_ms;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pin_q   <= PIN_OFF;
            idx_q   <= '0;
            ms_q    <= '0;
          end
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pin_out = pin_q;

endmodule
